// File: rtl/lsu_arbiter.sv
// rtl/lsu_arbiter.sv - two-port (data/fetch) load/store arbiter onto an 8-bit memory bus
// Define LSU_ARB_FAIR_EN for round-robin arbitration; otherwise data always beats fetch.
module lsu_arbiter (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        d_rq_start,
  input  logic        d_rq_cmd,
  input  logic        d_rq_width,
  input  logic        d_rq_tag,
  input  logic [15:0] d_rq_addr,
  input  logic [15:0] d_rq_wdata,
  input  logic        f_rq_start,
  input  logic [15:0] f_rq_addr,
  output logic        d_wait,
  output logic        f_wait,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_tag,
  output logic        rsp_src,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_cmd;
  logic        lat_width;
  logic        lat_tag;
  logic        lat_src;
  logic [7:0]  lat_lo;

  logic        idle;
  logic        grant_d;
  logic        grant_f;
  logic        complete;

  assign idle = (state == ST_IDLE);

`ifdef LSU_ARB_FAIR_EN
  // ptr_d=1 means data owns the tie-break; it hands over to the other port after every grant
  logic ptr_d;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      ptr_d <= 1'b1;
    end else if (grant_d || grant_f) begin
      ptr_d <= grant_f;
    end
  end

  assign grant_d = idle && d_rq_start && (!f_rq_start || ptr_d);
  assign grant_f = idle && f_rq_start && !grant_d;
`else
  assign grant_d = idle && d_rq_start;
  assign grant_f = idle && f_rq_start && !d_rq_start;
`endif

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_d || grant_f) begin
          state_nxt = ST_LO;
        end
      end
      ST_LO: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata[7:0];
        mem_rd    = !lat_cmd;
        mem_wr    = lat_cmd;
        if (mem_ready) begin
          if (lat_width) begin
            state_nxt = ST_HI;
          end else begin
            state_nxt = ST_IDLE;
            complete  = 1'b1;
          end
        end
      end
      ST_HI: begin
        mem_addr  = lat_addr + 16'd1;
        mem_wdata = lat_wdata[15:8];
        mem_rd    = !lat_cmd;
        mem_wr    = lat_cmd;
        if (mem_ready) begin
          state_nxt = ST_IDLE;
          complete  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latches carry no reset; everything they feed is qualified by state
  always_ff @(posedge clk) begin
    if (grant_d) begin
      lat_addr  <= d_rq_addr;
      lat_wdata <= d_rq_wdata;
      lat_cmd   <= d_rq_cmd;
      lat_width <= d_rq_width;
      lat_tag   <= d_rq_tag;
      lat_src   <= 1'b1;
    end else if (grant_f) begin
      lat_addr  <= f_rq_addr;
      lat_wdata <= 16'h0000;
      lat_cmd   <= 1'b0;
      lat_width <= 1'b1;
      lat_tag   <= 1'b0;
      lat_src   <= 1'b0;
    end
    if (state == ST_LO && mem_ready) begin
      lat_lo <= mem_rdata;
    end
  end

  assign d_wait = d_rq_start && !(complete && lat_src);
  assign f_wait = f_rq_start && !(complete && !lat_src);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_tag   <= 1'b0;
      rsp_src   <= 1'b0;
    end else begin
      rsp_valid <= complete && !lat_cmd;
      if (complete && !lat_cmd) begin
        rsp_data <= lat_width ? {mem_rdata, lat_lo} : {8'h00, mem_rdata};
        rsp_tag  <= lat_tag;
        rsp_src  <= lat_src;
      end
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb/tb_lsu_arbiter.sv - directed and randomized checks of lsu_arbiter against a byte-array memory model
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic        d_rq_start, d_rq_cmd, d_rq_width, d_rq_tag;
  logic [15:0] d_rq_addr, d_rq_wdata;
  logic        f_rq_start;
  logic [15:0] f_rq_addr;
  logic        d_wait, f_wait;
  logic        rsp_valid, rsp_tag, rsp_src;
  logic [15:0] rsp_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;

  logic [7:0]  mem [0:65535];

`ifdef LSU_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  lsu_arbiter dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .d_rq_start (d_rq_start),
    .d_rq_cmd   (d_rq_cmd),
    .d_rq_width (d_rq_width),
    .d_rq_tag   (d_rq_tag),
    .d_rq_addr  (d_rq_addr),
    .d_rq_wdata (d_rq_wdata),
    .f_rq_start (f_rq_start),
    .f_rq_addr  (f_rq_addr),
    .d_wait     (d_wait),
    .f_wait     (f_wait),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_src    (rsp_src),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on one port; stall_mode 0: ready always, 1: stall_n low cycles per beat, 2: random
  task automatic do_req(input bit sync, input bit port_d, input bit cmd, input bit width,
                        input bit tag, input logic [15:0] addr, input logic [15:0] wdata,
                        input int stall_mode, input int stall_n);
    logic [15:0] a1;
    logic [15:0] exp_rsp;
    int beats = 0;
    int low = 0;
    int cyc = 0;
    bit done = 1'b0;
    logic w;
    a1 = addr + 16'd1;
    if (!port_d) begin
      cmd = 1'b0;
      width = 1'b1;
    end
    exp_rsp = width ? {mem[a1], mem[addr]} : {8'h00, mem[addr]};
    if (sync) @(negedge clk);
    if (port_d) begin
      d_rq_start = 1'b1; d_rq_cmd = cmd; d_rq_width = width; d_rq_tag = tag;
      d_rq_addr = addr; d_rq_wdata = wdata;
    end else begin
      f_rq_start = 1'b1; f_rq_addr = addr;
    end
    while (!done && cyc < 80) begin
      case (stall_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = (low >= stall_n);
        default: mem_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      w = port_d ? d_wait : f_wait;
      if (cyc == 0) chk("rsp_idle", rsp_valid, 1'b0);
      chk("rd_wr_excl", mem_rd & mem_wr, 1'b0);
      if ((mem_rd || mem_wr) && mem_ready) begin
        chk("beat_addr", mem_addr, (beats == 0) ? addr : a1);
        chk("beat_dir", {mem_rd, mem_wr}, cmd ? 2'b01 : 2'b10);
        if (cmd) begin
          chk("beat_wdata", mem_wdata, (beats == 0) ? wdata[7:0] : wdata[15:8]);
          mem[(beats == 0) ? addr : a1] = mem_wdata;
        end
        beats++;
        low = 0;
      end else if (mem_rd || mem_wr) begin
        low++;
      end
      if (!w) begin
        done = 1'b1;
        chk("beats", beats, width ? 2 : 1);
        if (stall_mode == 0) chk("latency", cyc, width ? 2 : 1);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk("timeout", 1'b0, 1'b1);
    @(negedge clk);
    d_rq_start = 1'b0; f_rq_start = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rsp_valid", rsp_valid, !cmd);
    if (!cmd) begin
      chk("rsp_data", rsp_data, exp_rsp);
      chk("rsp_src", rsp_src, port_d);
      if (port_d) chk("rsp_tag", rsp_tag, tag);
    end
  endtask

  initial begin
    int order[$];
    int dn, fn, cyc;
    bit pend, exp_src, d_now, f_now;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    d_rq_start = 0; d_rq_cmd = 0; d_rq_width = 0; d_rq_tag = 0;
    d_rq_addr = 0; d_rq_wdata = 0; f_rq_start = 0; f_rq_addr = 0; mem_ready = 0;

    #1;
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_tag", rsp_tag, 1'b0);
    chk("rst_rsp_src", rsp_src, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b1;

    // byte load, word store across the address wrap, stalled fetch word
    mem[16'h1234] = 8'hAB;
    do_req(1, 1, 0, 0, 1, 16'h1234, 16'h0000, 0, 0);
    do_req(1, 1, 1, 1, 0, 16'hFFFF, 16'hBEEF, 0, 0);
    chk("wrap_store_lo", mem[16'hFFFF], 8'hEF);
    chk("wrap_store_hi", mem[16'h0000], 8'hBE);
    mem[16'h0100] = 8'h34;
    mem[16'h0101] = 8'h12;
    do_req(1, 0, 0, 0, 0, 16'h0100, 16'h0000, 1, 3);

    // reset during the high beat of a word load
    @(negedge clk);
    d_rq_start = 1; d_rq_cmd = 0; d_rq_width = 1; d_rq_tag = 1; d_rq_addr = 16'h2000;
    mem_ready = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("hi_beat_rd", mem_rd, 1'b1);
    chk("hi_beat_addr", mem_addr, 16'h2001);
    a_rst = 1'b0;
    #1;
    chk("rst_rd_drop", mem_rd, 1'b0);
    chk("rst_d_wait", d_wait, 1'b1);
    @(negedge clk);
    #1;
    chk("rst_no_rsp", rsp_valid, 1'b0);
    a_rst = 1'b1;
    do_req(0, 1, 0, 1, 1, 16'h2000, 16'h0000, 0, 0);

    // both ports contend for four loads each, starting from a fresh pointer
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    a_rst = 1'b1;
    mem_ready = 1;
    d_rq_start = 1; d_rq_cmd = 0; d_rq_width = 0; d_rq_tag = 0; d_rq_addr = 16'h3000;
    f_rq_start = 1; f_rq_addr = 16'h4000;
    dn = 0; fn = 0; cyc = 0; pend = 0; exp_src = 0;
    while ((dn < 4 || fn < 4) && cyc < 200) begin
      #1;
      if (pend) begin
        chk("arb_rsp_valid", rsp_valid, 1'b1);
        chk("arb_rsp_src", rsp_src, exp_src);
      end
      pend = 0; d_now = 0; f_now = 0;
      if (d_rq_start && !d_wait) begin
        order.push_back(1); dn++; d_now = 1; pend = 1; exp_src = 1;
      end
      if (f_rq_start && !f_wait) begin
        order.push_back(0); fn++; f_now = 1; pend = 1; exp_src = 0;
      end
      @(negedge clk);
      cyc++;
      if (d_now) begin
        d_rq_start = (dn < 4);
        d_rq_addr = d_rq_addr + 16'd1;
      end
      if (f_now) begin
        f_rq_start = (fn < 4);
        f_rq_addr = f_rq_addr + 16'd2;
      end
    end
    #1;
    if (pend) chk("arb_rsp_src", rsp_src, exp_src);
    chk("arb_count", order.size(), 8);
    for (int i = 0; i < order.size() && i < 8; i++) begin
      chk($sformatf("arb_order_%0d", i), order[i], FAIR ? ((i % 2) == 0) : (i < 4));
    end
    d_rq_start = 0; f_rq_start = 0; mem_ready = 0;

    // randomized single-port traffic
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      do_req(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ra,
             16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
